// File: rtl/h_xor_pkg.sv
// Shared constants and FSM encoding for the h_xor_checksum frame integrity checker.
package h_xor_pkg;

  localparam int HACK_WORD_W = 16;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/h_xor_word.sv
// Parametrised WIDTH-bit XOR; the multi-bit generalisation of the 1-bit XOR gate.
module h_xor_word #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);

  assign y = a ^ b;

endmodule

// File: rtl/h_xor_checksum.sv
// Folds a framed valid/ready stream of WIDTH-bit words into an XOR checksum with parity and beat count.
// Build option: define H_XOR_CHECKSUM_ROTATE_EN for an order-sensitive rotate-then-XOR accumulate.
module h_xor_checksum
  import h_xor_pkg::*;
#(
  parameter int  WIDTH   = HACK_WORD_W,
  parameter int  MAX_LEN = 255,
  localparam int CNT_W   = $clog2(MAX_LEN + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_parity,
  output logic [CNT_W-1:0] out_count,
  output logic             out_err
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_LEN);
  localparam logic [CNT_W-1:0] ONE_CNT = CNT_W'(1);

  state_t           state_r;
  logic [WIDTH-1:0] acc_r;
  logic [CNT_W-1:0] cnt_r;
  logic [WIDTH-1:0] acc_rot_s;
  logic [WIDTH-1:0] acc_nxt_s;
  logic [CNT_W-1:0] cnt_inc_s;

  function automatic logic parity_of(input logic [WIDTH-1:0] w);
    return ^w;
  endfunction

`ifdef H_XOR_CHECKSUM_ROTATE_EN
  generate
    if (WIDTH == 1) begin : g_rot_id
      assign acc_rot_s = acc_r;
    end else begin : g_rot
      assign acc_rot_s = {acc_r[WIDTH-2:0], acc_r[WIDTH-1]};
    end
  endgenerate
`else
  assign acc_rot_s = acc_r;
`endif

  h_xor_word #(.WIDTH(WIDTH)) u_word (
    .a (acc_rot_s),
    .b (in_data),
    .y (acc_nxt_s)
  );

  assign cnt_inc_s = cnt_r + ONE_CNT;

  // Ready is a pure decode of the state register so it never depends on in_valid.
  always_comb begin
    in_ready = 1'b0;
    case (state_r)
      S_IDLE:  in_ready = 1'b1;
      S_ACCUM: in_ready = 1'b1;
      S_DONE:  in_ready = 1'b0;
      default: in_ready = 1'b0;
    endcase
  end

  // Frame FSM with accumulator, beat counter and registered result outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= S_IDLE;
      acc_r      <= '0;
      cnt_r      <= '0;
      out_valid  <= 1'b0;
      out_sum    <= '0;
      out_parity <= 1'b0;
      out_count  <= '0;
      out_err    <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (in_valid) begin
            acc_r <= in_data;
            cnt_r <= ONE_CNT;
            if (in_last || (MAX_LEN == 1)) begin
              state_r    <= S_DONE;
              out_valid  <= 1'b1;
              out_sum    <= in_data;
              out_parity <= parity_of(in_data);
              out_count  <= ONE_CNT;
              out_err    <= ~in_last;
            end else begin
              state_r <= S_ACCUM;
            end
          end
        end
        S_ACCUM: begin
          if (in_valid) begin
            acc_r <= acc_nxt_s;
            cnt_r <= cnt_inc_s;
            // in_last takes priority over truncation on the same beat
            if (in_last || (cnt_inc_s == MAX_CNT)) begin
              state_r    <= S_DONE;
              out_valid  <= 1'b1;
              out_sum    <= acc_nxt_s;
              out_parity <= parity_of(acc_nxt_s);
              out_count  <= cnt_inc_s;
              out_err    <= ~in_last;
            end
          end
        end
        S_DONE: begin
          if (out_ready) begin
            state_r   <= S_IDLE;
            out_valid <= 1'b0;
          end
        end
        default: begin
          state_r   <= S_IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_h_xor_checksum.sv
// Randomised and directed bench for h_xor_checksum against a frame-level reference model.
module tb_h_xor_checksum;

  localparam int W   = 16;
  localparam int ML  = 4;
  localparam int CW  = $clog2(ML + 1);

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_data = '0;
  logic          in_last = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  out_sum;
  logic          out_parity;
  logic [CW-1:0] out_count;
  logic          out_err;

  int n_tests = 0;
  int n_fail  = 0;
  bit rnd_rdy = 1'b0;

  typedef struct {
    logic [W-1:0] sum;
    int           count;
    logic         err;
  } result_t;

  logic [W-1:0] frame_q[$];
  result_t      exp_q[$];
  bit           prev_hold = 1'b0;
  logic [W-1:0] prev_sum;

  h_xor_checksum #(.WIDTH(W), .MAX_LEN(ML)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_last    (in_last),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_sum    (out_sum),
    .out_parity (out_parity),
    .out_count  (out_count),
    .out_err    (out_err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] fold(input logic [W-1:0] s, input logic [W-1:0] d);
`ifdef H_XOR_CHECKSUM_ROTATE_EN
    return {s[W-2:0], s[W-1]} ^ d;
`else
    return s ^ d;
`endif
  endfunction

  // Reference model: collect beats of a frame, fold them when the frame closes.
  always @(negedge clk) begin
    if (reset) begin
      frame_q.delete();
      exp_q.delete();
      prev_hold = 1'b0;
    end else begin
      if (out_valid && prev_hold)
        check_eq("hold_sum", out_sum, prev_sum);
      prev_hold = out_valid && !out_ready;
      prev_sum  = out_sum;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check_eq("spurious_out", out_valid, 1'b0);
        end else begin
          result_t r;
          r = exp_q.pop_front();
          check_eq("sum", out_sum, r.sum);
          check_eq("parity", out_parity, $countones(r.sum) % 2);
          check_eq("count", out_count, r.count);
          check_eq("err", out_err, r.err);
        end
      end
      if (in_valid && in_ready) begin
        frame_q.push_back(in_data);
        if (in_last || frame_q.size() == ML) begin
          result_t r;
          r.sum = frame_q[0];
          for (int i = 1; i < frame_q.size(); i++) r.sum = fold(r.sum, frame_q[i]);
          r.count = frame_q.size();
          r.err   = !in_last;
          exp_q.push_back(r);
          frame_q.delete();
        end
      end
    end
  end

  // Random consumer back-pressure during the random phase.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rnd_rdy) out_ready = 1'($urandom_range(0, 1));
    end
  end

  // Present one beat and hold it until accepted (bounded wait).
  task automatic send(input logic [W-1:0] d, input logic l);
    int k;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    for (k = 0; k < 100; k++) begin
      @(negedge clk);
      if (in_ready) break;
    end
    if (k == 100) check_eq("in_ready_timeout", in_ready, 1'b1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_eq("rst_in_ready", in_ready, 1'b1);
    check_eq("rst_out_valid", out_valid, 1'b0);
    check_eq("rst_out_sum", out_sum, 16'h0000);
    check_eq("rst_out_count", out_count, 0);
    check_eq("rst_out_err", out_err, 1'b0);
    check_eq("rst_out_parity", out_parity, 1'b0);
    @(posedge clk);
    #1;

    // Three-beat frame with immediate consumer
    out_ready = 1'b1;
    send(16'h00FF, 1'b0);
    send(16'h0F0F, 1'b0);
    send(16'hFFFF, 1'b1);
    in_valid = 1'b0;
    @(negedge clk);
    check_eq("t1_latency", out_valid, 1'b1);
`ifndef H_XOR_CHECKSUM_ROTATE_EN
    check_eq("t1_sum", out_sum, 16'hF00F);
    check_eq("t1_parity", out_parity, 1'b0);
`endif
    check_eq("t1_count", out_count, 3);
    @(posedge clk);
    #1;

    // Single beat held under back-pressure
    out_ready = 1'b0;
    send(16'h0001, 1'b1);
    in_valid = 1'b1;
    in_data  = 16'h7777;
    in_last  = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check_eq("t2_in_ready", in_ready, 1'b0);
      check_eq("t2_valid", out_valid, 1'b1);
      check_eq("t2_sum", out_sum, 16'h0001);
      check_eq("t2_parity", out_parity, 1'b1);
      check_eq("t2_count", out_count, 1);
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;

    // Truncation at MAX_LEN, remaining beats start a new frame
    for (int i = 0; i < 4; i++) send(16'h0003, 1'b0);
    in_valid = 1'b0;
    @(negedge clk);
    check_eq("t3_err", out_err, 1'b1);
    check_eq("t3_count", out_count, 4);
`ifndef H_XOR_CHECKSUM_ROTATE_EN
    check_eq("t3_sum", out_sum, 16'h0000);
`endif
    @(posedge clk);
    #1;
    send(16'h0003, 1'b0);
    send(16'h0003, 1'b0);
    send(16'h0003, 1'b1);
    in_valid = 1'b0;
    @(negedge clk);
    check_eq("t3b_count", out_count, 3);
    check_eq("t3b_err", out_err, 1'b0);
    @(posedge clk);
    #1;

    // Reset mid-frame discards the partial frame
    send(16'h1234, 1'b0);
    send(16'h5678, 1'b0);
    in_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    send(16'hAAAA, 1'b1);
    in_valid = 1'b0;
    @(negedge clk);
    check_eq("t4_sum", out_sum, 16'hAAAA);
    check_eq("t4_count", out_count, 1);
    check_eq("t4_err", out_err, 1'b0);
    @(posedge clk);
    #1;

`ifdef H_XOR_CHECKSUM_ROTATE_EN
    // Order sensitivity of the rotate accumulate
    send(16'h8000, 1'b0);
    send(16'h0001, 1'b1);
    in_valid = 1'b0;
    @(negedge clk);
    check_eq("rot_sum_a", out_sum, 16'h0000);
    @(posedge clk);
    #1;
    send(16'h0001, 1'b0);
    send(16'h8000, 1'b1);
    in_valid = 1'b0;
    @(negedge clk);
    check_eq("rot_sum_b", out_sum, 16'h8002);
    @(posedge clk);
    #1;
`endif

    // Random back-to-back frames with gaps and back-pressure
    rnd_rdy = 1'b1;
    for (int f = 0; f < 40; f++) begin
      int len;
      len = $urandom_range(1, 6);
      for (int b = 0; b < len; b++) begin
        if ($urandom_range(0, 3) == 0) begin
          in_valid = 1'b0;
          repeat ($urandom_range(1, 2)) @(posedge clk);
          #1;
        end
        send(W'($urandom), (b == len - 1));
      end
    end
    in_valid = 1'b0;
    rnd_rdy  = 1'b0;
    @(posedge clk);
    #1 out_ready = 1'b1;
    for (int k = 0; k < 50 && exp_q.size() != 0; k++) @(posedge clk);
    @(negedge clk);
    check_eq("drain", exp_q.size(), 0);
    check_eq("final_idle", in_ready, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
